wb_regfile: RTL and testbench

//  Write-back stage plus architectural register file: the consumer of the MEM/WB pipeline register.

---
 rtl/wb_regfile_pkg.sv | 12 +
 rtl/wb_regfile_reg_array.sv | 35 +++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: data/index widths and the hardwired-zero register index.
// The pipeline registers and the forwarding unit use the same package.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int CNT_W  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_reg_array.sv
// Architectural register storage: one synchronous write port with reset clear,
// two asynchronous read ports, no bypass and no zero-register special case.
module wb_regfile_reg_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NREGS];

  // Reset wins over a write arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule : wb_regfile_reg_array

// File: rtl/wb_regfile.sv
// Write-back stage and register file: selects the write-back value, commits it,
// serves two write-through read ports and counts committed writes.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W,
  parameter int CNT_W  = wb_regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ReadData_in,
  input  logic [DATA_W-1:0] AluRes_in,
  input  logic [ADDR_W-1:0] Rd_in,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WbData,
  output logic              WbValid,
  output logic [CNT_W-1:0]  CommitCnt
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] arr_rdata1;
  logic [DATA_W-1:0] arr_rdata2;

  assign WbData  = MemToReg_in ? ReadData_in : AluRes_in;
  // Writes to the zero register are not commits; this also keeps them out of the bypass.
  assign WbValid = RegWrite_in && (Rd_in != ZERO_IDX);

  wb_regfile_reg_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_reg_array (
    .clk    (clk),
    .rst    (rst),
    .we     (WbValid),
    .waddr  (Rd_in),
    .wdata  (WbData),
    .raddr1 (Rs1),
    .raddr2 (Rs2),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // Write-first: a same-cycle commit to the read index is returned directly.
  always_comb begin
    ReadData1 = arr_rdata1;
    ReadData2 = arr_rdata2;
    if (Rs1 == ZERO_IDX) begin
      ReadData1 = '0;
    end else if (WbValid && (Rs1 == Rd_in)) begin
      ReadData1 = WbData;
    end
    if (Rs2 == ZERO_IDX) begin
      ReadData2 = '0;
    end else if (WbValid && (Rs2 == Rd_in)) begin
      ReadData2 = WbData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CommitCnt <= '0;
    end else if (WbValid) begin
      CommitCnt <= CommitCnt + 1'b1;
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic checked against
// an array-based register-file model. Counter is narrowed to 8 bits so wrap is reachable.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] read_data_in;
  logic [DW-1:0] alu_res_in;
  logic [AW-1:0] rd_in;
  logic          reg_write_in;
  logic          mem_to_reg_in;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic [DW-1:0] wb_data;
  logic          wb_valid;
  logic [CW-1:0] commit_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_regs [32];
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] exp_q [$];

  wb_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NREGS  (32),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ReadData_in (read_data_in),
    .AluRes_in   (alu_res_in),
    .Rd_in       (rd_in),
    .RegWrite_in (reg_write_in),
    .MemToReg_in (mem_to_reg_in),
    .Rs1         (rs1),
    .Rs2         (rs2),
    .ReadData1   (read_data1),
    .ReadData2   (read_data2),
    .WbData      (wb_data),
    .WbValid     (wb_valid),
    .CommitCnt   (commit_cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic we, input logic m2r, input logic [AW-1:0] rd,
                       input logic [DW-1:0] rdata, input logic [DW-1:0] alu,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    rst           = r;
    reg_write_in  = we;
    mem_to_reg_in = m2r;
    rd_in         = rd;
    read_data_in  = rdata;
    alu_res_in    = alu;
    rs1           = s1;
    rs2           = s2;
    #1;
  endtask

  // Model: the value the writeback presents, and whether it is a real commit.
  function automatic logic [DW-1:0] m_wb();
    return mem_to_reg_in ? read_data_in : alu_res_in;
  endfunction

  function automatic logic m_commit();
    return reg_write_in && (rd_in != 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (m_commit() && idx == rd_in) return m_wb();
    return m_regs[idx];
  endfunction

  // scoreboard: compare all outputs against the model for the currently driven inputs
  task automatic check_all(input string tag);
    exp_q.push_back(m_wb());
    exp_q.push_back(DW'(m_commit()));
    exp_q.push_back(m_read(rs1));
    exp_q.push_back(m_read(rs2));
    exp_q.push_back(DW'(m_cnt));
    check({tag, "_wbdata"}, wb_data, exp_q.pop_front());
    check({tag, "_wbvalid"}, DW'(wb_valid), exp_q.pop_front());
    check({tag, "_rd1"}, read_data1, exp_q.pop_front());
    check({tag, "_rd2"}, read_data2, exp_q.pop_front());
    check({tag, "_cnt"}, DW'(commit_cnt), exp_q.pop_front());
  endtask

  // One clock edge; the model takes the same step from the inputs held across it.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
    end else if (m_commit()) begin
      m_regs[rd_in] = m_wb();
      m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
    @(negedge clk);
    tick();

    // 1. reset state
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
    check("reset_cnt", DW'(commit_cnt), 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, AW'(i), AW'(32 - i));
      check("reset_rd1", read_data1, 32'h0);
      check("reset_rd2", read_data2, 32'h0);
    end

    // 2. ALU commit
    drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd0);
    check("alu_rd1", read_data1, 32'h1234);
    check("alu_cnt", DW'(commit_cnt), 32'h1);

    // 3. memory commit with same-cycle bypass
    drive(1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 32'h0, 5'd0, 5'd7);
    check("bypass_rd2", read_data2, 32'hDEADBEEF);
    check("bypass_wbdata", wb_data, 32'hDEADBEEF);
    check_all("bypass");
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7);
    check("mem_rd2", read_data2, 32'hDEADBEEF);
    check("mem_rd1", read_data1, 32'hDEADBEEF);
    check("mem_cnt", DW'(commit_cnt), 32'h2);

    // 4. zero register
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("zero_rd1", read_data1, 32'h0);
    check("zero_wbvalid", DW'(wb_valid), 32'h0);
    tick();
    check("zero_rd1_after", read_data1, 32'h0);
    check("zero_cnt", DW'(commit_cnt), 32'h2);

    // 5. write disabled
    drive(1'b0, 1'b0, 1'b0, 5'd5, 32'h0, 32'hAAAA, 5'd5, 5'd5);
    check("nowr_rd1", read_data1, 32'h1234);
    check("nowr_wbvalid", DW'(wb_valid), 32'h0);
    check("nowr_wbdata", wb_data, 32'hAAAA);
    tick();
    check("nowr_rd1_after", read_data1, 32'h1234);
    check("nowr_cnt", DW'(commit_cnt), 32'h2);

    // 6. reset beats a simultaneous commit
    drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0, 32'h77, 5'd9, 5'd5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h55, 5'd9, 5'd5);
    check("rst_wbvalid_comb", DW'(wb_valid), 32'h1);
    check("rst_wbdata_comb", wb_data, 32'h55);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd9, 32'h0, 32'h0, 5'd9, 5'd5);
    check("rstwr_rd1", read_data1, 32'h0);
    check("rstwr_rd2", read_data2, 32'h0);
    check("rstwr_cnt", DW'(commit_cnt), 32'h0);

    // counter wrap at 2**CW
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      drive(1'b0, 1'b1, $urandom_range(0, 1), AW'($urandom_range(1, 31)), $urandom, $urandom,
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd1, 5'd2);
    check("wrap_cnt_max", DW'(commit_cnt), 32'hFF);
    check_all("wrap_pre");
    drive(1'b0, 1'b1, 1'b0, 5'd3, '0, 32'h3, 5'd3, 5'd3);
    tick();
    check("wrap_cnt_zero", DW'(commit_cnt), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1), rd,
            $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? rd : AW'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? rd : AW'($urandom_range(0, 31)));
      check_all("rand");
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, AW'(i), AW'(31 - i));
      check_all("final");
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile
